// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Purpose  : PS/2 device-to-host receiver: clock filter, frame checking,
//            per-bit watchdog and a first-word-fall-through output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       rx_done_tick,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       overflow
);

  localparam int                   c_WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [c_WD_W-1:0]    c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 2);
  localparam logic [c_WD_W-1:0]    c_WD_ONE  = c_WD_W'(1);
  localparam int                   c_DEPTH_I = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]     c_DEPTH   = (FIFO_AW+1)'(c_DEPTH_I);
  localparam logic [FIFO_AW:0]     c_CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0]   c_PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // ---------------- clock filter ----------------
  logic [FILTER_LEN-1:0] r_filt;
  logic [FILTER_LEN-1:0] w_filt_next;
  logic                  r_fc;
  logic                  w_fc_next;
  logic                  w_fall;

  always_comb begin
    w_filt_next = {ps2c, r_filt[FILTER_LEN-1:1]};
    w_fc_next   = r_fc;
    if (&w_filt_next)
      w_fc_next = 1'b1;
    else if (~|w_filt_next)
      w_fc_next = 1'b0;
    w_fall = r_fc & ~w_fc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt <= '1;
      r_fc   <= 1'b1;
    end else begin
      r_filt <= w_filt_next;
      r_fc   <= w_fc_next;
    end
  end

  // ---------------- frame FSM ----------------
  state_t              r_state;
  state_t              w_state_next;
  logic [10:0]         r_shift;
  logic [3:0]          r_cnt;
  logic [c_WD_W-1:0]   r_wd;
  logic                w_start;
  logic                w_shift;
  logic                w_wd_inc;
  logic                w_timeout;
  logic                w_check;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_wd_inc     = 1'b0;
    w_timeout    = 1'b0;
    w_check      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && rx_en && !ps2d) begin
          w_start      = 1'b1;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_shift = 1'b1;
          if (r_cnt == 4'd0)
            w_state_next = S_CHECK;
        end else begin
          w_wd_inc = 1'b1;
          // counter is about to reach TIMEOUT_CYC-1 at this edge
          if (r_wd == c_WD_LAST) begin
            w_timeout    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_CHECK: begin
        w_check      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- frame evaluation ----------------
  logic w_frame_bad;
  logic w_par_ok;
  logic w_good;
  logic w_push;
  logic w_pop;
  logic w_ovf;
  logic r_empty;
  logic r_full;

  always_comb begin
    // start bit is always 0 once captured; included for completeness
    w_frame_bad = ~r_shift[10] | r_shift[0];
    w_par_ok    = ^r_shift[9:1];
    w_good      = w_check & ~w_frame_bad & w_par_ok;
    w_push      = w_good & (~r_full | rd_en);
    w_ovf       = w_good & ~w_push;
    w_pop       = rd_en & ~r_empty;
  end

  logic r_done;
  logic r_perr;
  logic r_ferr;
  logic r_terr;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= 4'd0;
      r_wd    <= '0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_terr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_push;
      r_perr <= w_check & ~w_frame_bad & ~w_par_ok;
      r_ferr <= w_check & w_frame_bad;
      r_terr <= w_timeout;
      r_ovf  <= w_ovf;
      if (w_start) begin
        r_shift <= {ps2d, r_shift[10:1]};
        r_cnt   <= 4'd9;
        r_wd    <= '0;
      end else if (w_shift) begin
        r_shift <= {ps2d, r_shift[10:1]};
        r_wd    <= '0;
        if (r_cnt != 4'd0)
          r_cnt <= r_cnt - 4'd1;
      end else if (w_wd_inc) begin
        r_wd <= r_wd + c_WD_ONE;
      end
    end
  end

  // ---------------- output FIFO ----------------
  logic [7:0]         r_mem [c_DEPTH_I];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [FIFO_AW:0]   w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + c_CNT_ONE;
    else if (!w_push && w_pop)
      w_count_next = r_count - c_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= r_shift[8:1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == c_DEPTH);
    end
  end

  assign dout         = r_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty        = r_empty;
  assign full         = r_full;
  assign rx_done_tick = r_done;
  assign err_parity   = r_perr;
  assign err_frame    = r_ferr;
  assign err_timeout  = r_terr;
  assign overflow     = r_ovf;

endmodule
`default_nettype wire
